// File: rtl/button_entry_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : button_entry_pkg                                          |
// | Brief    : Shared constants and event codes for button word entry    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package button_entry_pkg;

  // Fill-mode selectors for the MODE parameter
  localparam int MODE_SHIFT = 0;
  localparam int MODE_LOCK  = 1;

  // One decoded edit event per cycle after priority resolution
  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_ZERO   = 3'd1,
    EV_ONE    = 3'd2,
    EV_DEL    = 3'd3,
    EV_COMMIT = 3'd4
  } event_t;

endpackage
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : btn_conditioner                                           |
// | Brief    : 2-FF synchroniser, debouncer and rising-edge press pulse  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module btn_conditioner #(
  parameter int DEB_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  // Counter only has to reach DEB_CYC-1; keep at least one bit for DEB_CYC=1
  localparam int              c_CNT_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYC - 1);

  logic               r_s1;
  logic               r_s2;
  logic               r_level;
  logic               r_level_q;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_press;

  // Bring the asynchronous button level into the clock domain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
    end
  end

  // Accept a new level only after DEB_CYC consecutive disagreeing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_s2 != r_level) begin
      if (r_cnt == c_CNT_LAST) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  // One-cycle pulse on the edge after the debounced level rises
  always_ff @(posedge clk) begin
    if (reset) begin
      r_level_q <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_level_q <= r_level;
      r_press   <= r_level & ~r_level_q;
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/button_word_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : button_word_entry                                         |
// | Brief    : Push-button N-bit word capture with delete and commit     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module button_word_entry
  import button_entry_pkg::*;
#(
  parameter int N       = 8,
  parameter int DEB_CYC = 16,
  parameter int MODE    = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     zeroes,
  input  logic                     ones,
  input  logic                     del,
  input  logic                     commit,
  output logic [N-1:0]             bus,
  output logic [$clog2(N+1)-1:0]   count,
  output logic                     full,
  output logic [N-1:0]             word,
  output logic                     word_valid,
  output logic                     overflow
);

  localparam int c_CW = $clog2(N + 1);

  logic [3:0]      w_raw;
  logic [3:0]      w_press;
  event_t          w_event;
  logic            w_full;
  logic [N-1:0]    w_shifted;

  logic [N-1:0]    r_bus;
  logic [c_CW-1:0] r_cnt;
  logic [N-1:0]    r_word;
  logic            r_word_valid;
  logic            r_overflow;

  logic [N-1:0]    w_bus_nxt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic [N-1:0]    w_word_nxt;
  logic            w_wv_nxt;
  logic            w_ov_nxt;

  // Bit order matches the priority encoder below: commit, del, ones, zeroes
  assign w_raw = {commit, del, ones, zeroes};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_conditioner #(
      .DEB_CYC (DEB_CYC)
    ) u_cond (
      .clk   (clk),
      .reset (reset),
      .raw   (w_raw[gi]),
      .press (w_press[gi])
    );
  end

  assign w_full    = (r_cnt == c_CW'(N));
  assign w_shifted = {r_bus[N-2:0], (w_event == EV_ONE)};

  // Resolve simultaneous presses: commit beats del beats a lone data button
  always_comb begin
    w_event = EV_NONE;
    if (w_press[3]) begin
      w_event = EV_COMMIT;
    end else if (w_press[2]) begin
      w_event = EV_DEL;
    end else if (w_press[1] ^ w_press[0]) begin
      w_event = w_press[1] ? EV_ONE : EV_ZERO;
    end
  end

  // Next-state of the word datapath for the resolved event
  always_comb begin
    w_bus_nxt  = r_bus;
    w_cnt_nxt  = r_cnt;
    w_word_nxt = r_word;
    w_wv_nxt   = 1'b0;
    w_ov_nxt   = 1'b0;
    case (w_event)
      EV_ZERO, EV_ONE: begin
        if (!w_full) begin
          w_bus_nxt = w_shifted;
          w_cnt_nxt = r_cnt + c_CW'(1);
        end else begin
          w_ov_nxt = 1'b1;
          if (MODE == MODE_SHIFT) begin
            w_bus_nxt = w_shifted;
          end
        end
      end
      EV_DEL: begin
        if (r_cnt != '0) begin
          w_bus_nxt = r_bus >> 1;
          w_cnt_nxt = r_cnt - c_CW'(1);
        end
      end
      EV_COMMIT: begin
        w_word_nxt = r_bus;
        w_wv_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus        <= '0;
      r_cnt        <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_bus        <= w_bus_nxt;
      r_cnt        <= w_cnt_nxt;
      r_word       <= w_word_nxt;
      r_word_valid <= w_wv_nxt;
      r_overflow   <= w_ov_nxt;
    end
  end

  assign bus        = r_bus;
  assign count      = r_cnt;
  assign full       = w_full;
  assign word       = r_word;
  assign word_valid = r_word_valid;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_button_word_entry.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_button_word_entry                                      |
// | Brief    : Directed table-driven bench for button_word_entry         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_button_word_entry;

  localparam int c_DEB = 4;
  localparam logic [3:0] B_Z = 4'b0001;
  localparam logic [3:0] B_O = 4'b0010;
  localparam logic [3:0] B_D = 4'b0100;
  localparam logic [3:0] B_C = 4'b1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic zeroes = 1'b0, ones = 1'b0, del = 1'b0, commit = 1'b0;

  logic [3:0] s4_bus, s4_word;  logic [2:0] s4_cnt; logic s4_full, s4_wv, s4_ov;
  logic [3:0] l4_bus, l4_word;  logic [2:0] l4_cnt; logic l4_full, l4_wv, l4_ov;
  logic [7:0] s8_bus, s8_word;  logic [3:0] s8_cnt; logic s8_full, s8_wv, s8_ov;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_word_entry #(.N(4), .DEB_CYC(c_DEB), .MODE(0)) dut_s4 (
    .clk(clk), .reset(reset), .zeroes(zeroes), .ones(ones), .del(del), .commit(commit),
    .bus(s4_bus), .count(s4_cnt), .full(s4_full), .word(s4_word),
    .word_valid(s4_wv), .overflow(s4_ov));

  button_word_entry #(.N(4), .DEB_CYC(c_DEB), .MODE(1)) dut_l4 (
    .clk(clk), .reset(reset), .zeroes(zeroes), .ones(ones), .del(del), .commit(commit),
    .bus(l4_bus), .count(l4_cnt), .full(l4_full), .word(l4_word),
    .word_valid(l4_wv), .overflow(l4_ov));

  button_word_entry #(.N(8), .DEB_CYC(c_DEB), .MODE(0)) dut_s8 (
    .clk(clk), .reset(reset), .zeroes(zeroes), .ones(ones), .del(del), .commit(commit),
    .bus(s8_bus), .count(s8_cnt), .full(s8_full), .word(s8_word),
    .word_valid(s8_wv), .overflow(s8_ov));

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] s4_bus; logic [2:0] s4_cnt; logic s4_ov; logic [3:0] s4_word;
    logic [3:0] l4_bus; logic [2:0] l4_cnt; logic l4_ov;
    logic [7:0] s8_bus; logic [3:0] s8_cnt; logic [7:0] s8_word; logic s8_wv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic r, input logic [3:0] b,
    input logic [3:0] sb, input logic [2:0] sc, input logic so, input logic [3:0] sw,
    input logic [3:0] lb, input logic [2:0] lc, input logic lo,
    input logic [7:0] eb, input logic [3:0] ec, input logic [7:0] ew, input logic ev);
    vec_t v;
    v.rst = r; v.btn = b;
    v.s4_bus = sb; v.s4_cnt = sc; v.s4_ov = so; v.s4_word = sw;
    v.l4_bus = lb; v.l4_cnt = lc; v.l4_ov = lo;
    v.s8_bus = eb; v.s8_cnt = ec; v.s8_word = ew; v.s8_wv = ev;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] m);
    {commit, del, ones, zeroes} = m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(4'b0000);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Press, wait for the update edge E+DEB+3 and release with settling time
  task automatic press_only(input logic [3:0] m);
    @(negedge clk);
    drive(m);
    repeat (c_DEB + 4) @(posedge clk);
    @(negedge clk);
    drive(4'b0000);
    repeat (c_DEB + 6) @(posedge clk);
  endtask

  task automatic apply(input int i, input vec_t v);
    if (v.rst) do_reset();
    @(negedge clk);
    drive(v.btn);
    repeat (c_DEB + 4) @(posedge clk);
    #1;
    chk($sformatf("v%0d s4_bus", i),  s4_bus,  v.s4_bus);
    chk($sformatf("v%0d s4_cnt", i),  s4_cnt,  v.s4_cnt);
    chk($sformatf("v%0d s4_full", i), s4_full, (v.s4_cnt == 3'd4));
    chk($sformatf("v%0d s4_ov", i),   s4_ov,   v.s4_ov);
    chk($sformatf("v%0d s4_word", i), s4_word, v.s4_word);
    chk($sformatf("v%0d l4_bus", i),  l4_bus,  v.l4_bus);
    chk($sformatf("v%0d l4_cnt", i),  l4_cnt,  v.l4_cnt);
    chk($sformatf("v%0d l4_ov", i),   l4_ov,   v.l4_ov);
    chk($sformatf("v%0d s8_bus", i),  s8_bus,  v.s8_bus);
    chk($sformatf("v%0d s8_cnt", i),  s8_cnt,  v.s8_cnt);
    chk($sformatf("v%0d s8_word", i), s8_word, v.s8_word);
    chk($sformatf("v%0d s8_wv", i),   s8_wv,   v.s8_wv);
    chk($sformatf("v%0d s8_ov", i),   s8_ov,   1'b0);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d s4_ov_end", i), s4_ov, 1'b0);
    chk($sformatf("v%0d l4_ov_end", i), l4_ov, 1'b0);
    chk($sformatf("v%0d s8_wv_end", i), s8_wv, 1'b0);
    @(negedge clk);
    drive(4'b0000);
    repeat (c_DEB + 6) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int pulses;

    // SHIFT fill/overflow, LOCK rejection, delete, simultaneous presses
    tbl.push_back(mk(1'b1, B_O,       4'h1,3'd1,1'b0,4'h0, 4'h1,3'd1,1'b0, 8'h01,4'd1,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_Z,       4'h2,3'd2,1'b0,4'h0, 4'h2,3'd2,1'b0, 8'h02,4'd2,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_O,       4'h5,3'd3,1'b0,4'h0, 4'h5,3'd3,1'b0, 8'h05,4'd3,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_O,       4'hB,3'd4,1'b0,4'h0, 4'hB,3'd4,1'b0, 8'h0B,4'd4,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_Z,       4'h6,3'd4,1'b1,4'h0, 4'hB,3'd4,1'b1, 8'h16,4'd5,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_D,       4'h3,3'd3,1'b0,4'h0, 4'h5,3'd3,1'b0, 8'h0B,4'd4,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_Z|B_O,   4'h3,3'd3,1'b0,4'h0, 4'h5,3'd3,1'b0, 8'h0B,4'd4,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_D|B_O,   4'h1,3'd2,1'b0,4'h0, 4'h2,3'd2,1'b0, 8'h05,4'd3,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_C|B_Z,   4'h1,3'd2,1'b0,4'h1, 4'h2,3'd2,1'b0, 8'h05,4'd3,8'h05,1'b1));
    // del on an empty word does nothing
    tbl.push_back(mk(1'b1, B_D,       4'h0,3'd0,1'b0,4'h0, 4'h0,3'd0,1'b0, 8'h00,4'd0,8'h00,1'b0));
    // LOCK: fill 1111, reject a 0, then delete
    tbl.push_back(mk(1'b0, B_O,       4'h1,3'd1,1'b0,4'h0, 4'h1,3'd1,1'b0, 8'h01,4'd1,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_O,       4'h3,3'd2,1'b0,4'h0, 4'h3,3'd2,1'b0, 8'h03,4'd2,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_O,       4'h7,3'd3,1'b0,4'h0, 4'h7,3'd3,1'b0, 8'h07,4'd3,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_O,       4'hF,3'd4,1'b0,4'h0, 4'hF,3'd4,1'b0, 8'h0F,4'd4,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_Z,       4'hE,3'd4,1'b1,4'h0, 4'hF,3'd4,1'b1, 8'h1E,4'd5,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_D,       4'h7,3'd3,1'b0,4'h0, 4'h7,3'd3,1'b0, 8'h0F,4'd4,8'h00,1'b0));
    // Build 8'h5A and commit it
    tbl.push_back(mk(1'b1, B_Z,       4'h0,3'd1,1'b0,4'h0, 4'h0,3'd1,1'b0, 8'h00,4'd1,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_O,       4'h1,3'd2,1'b0,4'h0, 4'h1,3'd2,1'b0, 8'h01,4'd2,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_Z,       4'h2,3'd3,1'b0,4'h0, 4'h2,3'd3,1'b0, 8'h02,4'd3,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_O,       4'h5,3'd4,1'b0,4'h0, 4'h5,3'd4,1'b0, 8'h05,4'd4,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_O,       4'hB,3'd4,1'b1,4'h0, 4'h5,3'd4,1'b1, 8'h0B,4'd5,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_Z,       4'h6,3'd4,1'b1,4'h0, 4'h5,3'd4,1'b1, 8'h16,4'd6,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_O,       4'hD,3'd4,1'b1,4'h0, 4'h5,3'd4,1'b1, 8'h2D,4'd7,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_Z,       4'hA,3'd4,1'b1,4'h0, 4'h5,3'd4,1'b1, 8'h5A,4'd8,8'h00,1'b0));
    tbl.push_back(mk(1'b0, B_C,       4'hA,3'd4,1'b0,4'hA, 4'h5,3'd4,1'b0, 8'h5A,4'd8,8'h5A,1'b1));

    // Reset state
    do_reset();
    #1;
    chk("rst s4_bus", s4_bus, 4'h0);
    chk("rst s4_cnt", s4_cnt, 3'd0);
    chk("rst s4_full", s4_full, 1'b0);
    chk("rst s4_word", s4_word, 4'h0);
    chk("rst s4_wv", s4_wv, 1'b0);
    chk("rst s4_ov", s4_ov, 1'b0);
    chk("rst s8_bus", s8_bus, 8'h00);
    chk("rst s8_cnt", s8_cnt, 4'd0);

    foreach (tbl[i]) apply(i, tbl[i]);

    chk("s8 full at 8", s8_full, 1'b1);

    // Held commit: exactly one pulse, none on release, another on re-press
    pulses = 0;
    @(negedge clk);
    drive(B_C);
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (s8_wv) pulses++;
    end
    chk("held commit pulses", pulses, 1);
    @(negedge clk);
    drive(4'b0000);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (s8_wv) pulses++;
    end
    chk("commit release pulses", pulses, 1);
    @(negedge clk);
    drive(B_C);
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (s8_wv) pulses++;
    end
    chk("commit repress pulses", pulses, 2);
    chk("commit repress word", s8_word, 8'h5A);
    @(negedge clk);
    drive(4'b0000);
    repeat (12) @(posedge clk);

    // Bounce on ones: no pulse while bouncing, one append at E+DEB+3
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ones = ~ones;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("bounce no append", s4_cnt, 3'd0);
    ones = 1'b1;
    repeat (c_DEB + 3) @(posedge clk);
    #1;
    chk("bounce E+6 bus", s4_bus, 4'h0);
    @(posedge clk); #1;
    chk("bounce E+7 bus", s4_bus, 4'h1);
    chk("bounce E+7 cnt", s4_cnt, 3'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("bounce single append", s4_cnt, 3'd1);
    @(negedge clk);
    ones = 1'b0;
    repeat (12) @(posedge clk);

    // Reset during debounce with count=3, ones held through release
    do_reset();
    press_only(B_O);
    press_only(B_O);
    press_only(B_O);
    #1;
    chk("pre-reset cnt", s4_cnt, 3'd3);
    @(negedge clk);
    ones = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst s4_bus", s4_bus, 4'h0);
    chk("midrst s4_cnt", s4_cnt, 3'd0);
    chk("midrst s4_full", s4_full, 1'b0);
    chk("midrst s4_word", s4_word, 4'h0);
    chk("midrst s4_ov", s4_ov, 1'b0);
    chk("midrst s4_wv", s4_wv, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (c_DEB + 3) @(posedge clk);
    #1;
    chk("postrst R+6 bus", s4_bus, 4'h0);
    @(posedge clk); #1;
    chk("postrst R+7 bus", s4_bus, 4'h1);
    chk("postrst R+7 cnt", s4_cnt, 3'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("postrst single append", s4_cnt, 3'd1);
    @(negedge clk);
    ones = 1'b0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
